// File: rtl/rpc2_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// rpc2_ctrl_pkg
// Constants shared by the RPC2 controller AXI front end and the command-FIFO
// consumers. The command word is {AWADDR, AWLEN, AWSIZE, AWBURST}, MSB first.
// Consumers slice it with the *_LSB / *_W constants below so that producer and
// consumer always agree on the layout.
// ---------------------------------------------------------------------------
package rpc2_ctrl_pkg;

   localparam int unsigned CMD_BURST_W   = 2;
   localparam int unsigned CMD_SIZE_W    = 3;
   localparam int unsigned CMD_LEN_W     = 8;
   // Bits below the address field in a command word
   localparam int unsigned CMD_TAIL_W    = CMD_LEN_W + CMD_SIZE_W + CMD_BURST_W;

   localparam int unsigned CMD_BURST_LSB = 0;
   localparam int unsigned CMD_SIZE_LSB  = CMD_BURST_LSB + CMD_BURST_W;
   localparam int unsigned CMD_LEN_LSB   = CMD_SIZE_LSB + CMD_SIZE_W;
   localparam int unsigned CMD_ADDR_LSB  = CMD_LEN_LSB + CMD_LEN_W;

   // Target chosen by the address select bit
   typedef enum logic {
      TGT0 = 1'b0,
      TGT1 = 1'b1
   } tgt_sel_e;

endpackage

// File: rtl/rpc2_ctrl_outstanding_counter.sv
// ---------------------------------------------------------------------------
// rpc2_ctrl_outstanding_counter
// Counts writes issued to one target that the response side has not retired.
//   clk, reset : clock, asynchronous active-high reset
//   inc        : a write was pushed to the target this cycle
//   dec        : retire pulse from the write-response side
//   count      : current number of unretired writes
//   at_max     : count has reached C_MAX (caller must stop pushing)
// ---------------------------------------------------------------------------
module rpc2_ctrl_outstanding_counter #(
   parameter  int unsigned C_MAX = 8,
   localparam int unsigned CW    = $clog2(C_MAX + 1)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          inc,
   input  logic          dec,
   output logic [CW-1:0] count,
   output logic          at_max
);

   logic [CW-1:0] cnt_q, cnt_d;
   logic          dec_eff;

   always_comb begin
      // A retire with nothing outstanding is spurious and dropped
      dec_eff = dec & (cnt_q != '0);
      cnt_d   = cnt_q;
      if (inc & ~dec_eff)
         cnt_d = cnt_q + CW'(1);
      else if (dec_eff & ~inc)
         cnt_d = cnt_q - CW'(1);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         cnt_q <= '0;
      else
         cnt_q <= cnt_d;
   end

   assign count  = cnt_q;
   assign at_max = (cnt_q == CW'(C_MAX));

endmodule

// File: rtl/rpc2_ctrl_axi_wr_address_channel2.sv
// ---------------------------------------------------------------------------
// rpc2_ctrl_axi_wr_address_channel2
// AXI write-address channel front end. Each accepted AW beat is parked in a
// one-entry holding register, then pushed together into the selected target's
// response-ID FIFO and command FIFO once that target has room and fewer than
// C_MAX_OUTSTANDING unretired writes.
//   clk, reset            : clock, asynchronous active-high reset
//   AXI_AW*               : AXI write-address channel (slave side)
//   awidN_fifo_wr_en/din  : push of the write ID for target N
//   awidN_fifo_full       : target N ID FIFO full
//   awidN_fifo_rd_en      : retire pulse for target N (response side)
//   cmdN_wr_en/din        : push of {AWADDR, AWLEN, AWSIZE, AWBURST} to target N
//   cmdN_full             : target N command FIFO full
//   wr_pending            : registered, a write is held or still outstanding
// ---------------------------------------------------------------------------
module rpc2_ctrl_axi_wr_address_channel2
   import rpc2_ctrl_pkg::*;
#(
   parameter int C_AXI_ID_WIDTH    = 4,
   parameter int C_AXI_ADDR_WIDTH  = 32,
   parameter int C_SEL_BIT         = 31,
   parameter int C_MAX_OUTSTANDING = 8
) (
   input  logic                                   clk,
   input  logic                                   reset,
   input  logic [C_AXI_ID_WIDTH-1:0]              AXI_AWID,
   input  logic [C_AXI_ADDR_WIDTH-1:0]            AXI_AWADDR,
   input  logic [7:0]                             AXI_AWLEN,
   input  logic [2:0]                             AXI_AWSIZE,
   input  logic [1:0]                             AXI_AWBURST,
   input  logic                                   AXI_AWVALID,
   output logic                                   AXI_AWREADY,
   output logic                                   awid0_fifo_wr_en,
   output logic [C_AXI_ID_WIDTH-1:0]              awid0_fifo_din,
   input  logic                                   awid0_fifo_full,
   input  logic                                   awid0_fifo_rd_en,
   output logic                                   awid1_fifo_wr_en,
   output logic [C_AXI_ID_WIDTH-1:0]              awid1_fifo_din,
   input  logic                                   awid1_fifo_full,
   input  logic                                   awid1_fifo_rd_en,
   output logic                                   cmd0_wr_en,
   output logic [C_AXI_ADDR_WIDTH+CMD_TAIL_W-1:0] cmd0_din,
   input  logic                                   cmd0_full,
   output logic                                   cmd1_wr_en,
   output logic [C_AXI_ADDR_WIDTH+CMD_TAIL_W-1:0] cmd1_din,
   input  logic                                   cmd1_full,
   output logic                                   wr_pending
);

   localparam int unsigned CNT_W = $clog2(C_MAX_OUTSTANDING + 1);

   logic                          hold_valid_q, hold_valid_d;
   logic [C_AXI_ID_WIDTH-1:0]     hold_id_q,    hold_id_d;
   logic [C_AXI_ADDR_WIDTH-1:0]   hold_addr_q,  hold_addr_d;
   logic [CMD_LEN_W-1:0]          hold_len_q,   hold_len_d;
   logic [CMD_SIZE_W-1:0]         hold_size_q,  hold_size_d;
   logic [CMD_BURST_W-1:0]        hold_burst_q, hold_burst_d;
   tgt_sel_e                      hold_sel_q,   hold_sel_d;
   logic                          awready_q;
   logic                          wr_pending_q;

   logic                          accept;
   logic                          push0, push1;
   logic                          at_max0, at_max1;
   logic [CNT_W-1:0]              cnt0, cnt1;
   logic [C_AXI_ADDR_WIDTH+CMD_TAIL_W-1:0] cmd_w;

   assign accept = AXI_AWVALID & awready_q;

   // Only the held command's own target gates the push; the other target's
   // full flags are irrelevant.
   assign push0 = hold_valid_q & (hold_sel_q == TGT0) & ~awid0_fifo_full
                & ~cmd0_full & ~at_max0;
   assign push1 = hold_valid_q & (hold_sel_q == TGT1) & ~awid1_fifo_full
                & ~cmd1_full & ~at_max1;

   always_comb begin
      hold_valid_d = hold_valid_q;
      hold_id_d    = hold_id_q;
      hold_addr_d  = hold_addr_q;
      hold_len_d   = hold_len_q;
      hold_size_d  = hold_size_q;
      hold_burst_d = hold_burst_q;
      hold_sel_d   = hold_sel_q;
      // accept needs AWREADY (= empty holder), push needs a full holder,
      // so the two never coincide
      if (accept) begin
         hold_valid_d = 1'b1;
         hold_id_d    = AXI_AWID;
         hold_addr_d  = AXI_AWADDR;
         hold_len_d   = AXI_AWLEN;
         hold_size_d  = AXI_AWSIZE;
         hold_burst_d = AXI_AWBURST;
         hold_sel_d   = tgt_sel_e'(AXI_AWADDR[C_SEL_BIT]);
      end else if (push0 | push1) begin
         hold_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         hold_valid_q <= 1'b0;
         hold_id_q    <= '0;
         hold_addr_q  <= '0;
         hold_len_q   <= '0;
         hold_size_q  <= '0;
         hold_burst_q <= '0;
         hold_sel_q   <= TGT0;
         awready_q    <= 1'b1;
         wr_pending_q <= 1'b0;
      end else begin
         hold_valid_q <= hold_valid_d;
         hold_id_q    <= hold_id_d;
         hold_addr_q  <= hold_addr_d;
         hold_len_q   <= hold_len_d;
         hold_size_q  <= hold_size_d;
         hold_burst_q <= hold_burst_d;
         hold_sel_q   <= hold_sel_d;
         awready_q    <= ~hold_valid_d;
         wr_pending_q <= hold_valid_q | (cnt0 != '0) | (cnt1 != '0);
      end
   end

   always_comb begin
      cmd_w = '0;
      cmd_w[CMD_ADDR_LSB  +: C_AXI_ADDR_WIDTH] = hold_addr_q;
      cmd_w[CMD_LEN_LSB   +: CMD_LEN_W]        = hold_len_q;
      cmd_w[CMD_SIZE_LSB  +: CMD_SIZE_W]       = hold_size_q;
      cmd_w[CMD_BURST_LSB +: CMD_BURST_W]      = hold_burst_q;
   end

   rpc2_ctrl_outstanding_counter #(
      .C_MAX (C_MAX_OUTSTANDING)
   ) u_cnt0 (
      .clk    (clk),
      .reset  (reset),
      .inc    (push0),
      .dec    (awid0_fifo_rd_en),
      .count  (cnt0),
      .at_max (at_max0)
   );

   rpc2_ctrl_outstanding_counter #(
      .C_MAX (C_MAX_OUTSTANDING)
   ) u_cnt1 (
      .clk    (clk),
      .reset  (reset),
      .inc    (push1),
      .dec    (awid1_fifo_rd_en),
      .count  (cnt1),
      .at_max (at_max1)
   );

   assign AXI_AWREADY      = awready_q;
   assign awid0_fifo_wr_en = push0;
   assign cmd0_wr_en       = push0;
   assign awid1_fifo_wr_en = push1;
   assign cmd1_wr_en       = push1;
   assign awid0_fifo_din   = hold_id_q;
   assign awid1_fifo_din   = hold_id_q;
   assign cmd0_din         = cmd_w;
   assign cmd1_din         = cmd_w;
   assign wr_pending       = wr_pending_q;

endmodule

// File: tb/tb_rpc2_ctrl_axi_wr_address_channel2.sv
module tb_rpc2_ctrl_axi_wr_address_channel2;

   localparam int IDW  = 4;
   localparam int AW   = 32;
   localparam int SEL  = 31;
   localparam int MAXO = 8;

   logic            clk = 1'b0;
   logic            reset = 1'b1;
   logic [IDW-1:0]  AXI_AWID;
   logic [AW-1:0]   AXI_AWADDR;
   logic [7:0]      AXI_AWLEN;
   logic [2:0]      AXI_AWSIZE;
   logic [1:0]      AXI_AWBURST;
   logic            AXI_AWVALID;
   logic            AXI_AWREADY;
   logic            awid0_fifo_wr_en, awid1_fifo_wr_en;
   logic [IDW-1:0]  awid0_fifo_din, awid1_fifo_din;
   logic            awid0_fifo_full, awid1_fifo_full;
   logic            awid0_fifo_rd_en, awid1_fifo_rd_en;
   logic            cmd0_wr_en, cmd1_wr_en;
   logic [AW+12:0]  cmd0_din, cmd1_din;
   logic            cmd0_full, cmd1_full;
   logic            wr_pending;

   int errors = 0;
   int checks = 0;

   rpc2_ctrl_axi_wr_address_channel2 #(
      .C_AXI_ID_WIDTH    (IDW),
      .C_AXI_ADDR_WIDTH  (AW),
      .C_SEL_BIT         (SEL),
      .C_MAX_OUTSTANDING (MAXO)
   ) dut (
      .clk              (clk),
      .reset            (reset),
      .AXI_AWID         (AXI_AWID),
      .AXI_AWADDR       (AXI_AWADDR),
      .AXI_AWLEN        (AXI_AWLEN),
      .AXI_AWSIZE       (AXI_AWSIZE),
      .AXI_AWBURST      (AXI_AWBURST),
      .AXI_AWVALID      (AXI_AWVALID),
      .AXI_AWREADY      (AXI_AWREADY),
      .awid0_fifo_wr_en (awid0_fifo_wr_en),
      .awid0_fifo_din   (awid0_fifo_din),
      .awid0_fifo_full  (awid0_fifo_full),
      .awid0_fifo_rd_en (awid0_fifo_rd_en),
      .awid1_fifo_wr_en (awid1_fifo_wr_en),
      .awid1_fifo_din   (awid1_fifo_din),
      .awid1_fifo_full  (awid1_fifo_full),
      .awid1_fifo_rd_en (awid1_fifo_rd_en),
      .cmd0_wr_en       (cmd0_wr_en),
      .cmd0_din         (cmd0_din),
      .cmd0_full        (cmd0_full),
      .cmd1_wr_en       (cmd1_wr_en),
      .cmd1_din         (cmd1_din),
      .cmd1_full        (cmd1_full),
      .wr_pending       (wr_pending)
   );

   always #5 clk = ~clk;

   // Expected command word: {AWADDR, AWLEN, AWSIZE, AWBURST}, MSB first
   function automatic logic [AW+12:0] pack(input logic [AW-1:0] a, input logic [7:0] l,
                                           input logic [2:0] s, input logic [1:0] b);
      return {a, l, s, b};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      AXI_AWVALID = 1'b0;  AXI_AWID = '0;  AXI_AWADDR = '0;
      AXI_AWLEN = '0;      AXI_AWSIZE = '0; AXI_AWBURST = '0;
      awid0_fifo_full = 1'b0; awid1_fifo_full = 1'b0;
      awid0_fifo_rd_en = 1'b0; awid1_fifo_rd_en = 1'b0;
      cmd0_full = 1'b0; cmd1_full = 1'b0;
      tick(); tick();
      reset = 1'b0;
      #1;
   endtask

   // Present one AW beat, wait (bounded) for AWREADY, accept it, and return
   // settled in the cycle after acceptance.
   task automatic write_aw(input int id, input logic [AW-1:0] addr, input int len,
                           input int size, input int burst);
      AXI_AWVALID = 1'b1;
      AXI_AWID    = IDW'(id);
      AXI_AWADDR  = addr;
      AXI_AWLEN   = 8'(len);
      AXI_AWSIZE  = 3'(size);
      AXI_AWBURST = 2'(burst);
      #1;
      for (int g = 0; g < 20 && AXI_AWREADY !== 1'b1; g++) tick();
      if (AXI_AWREADY !== 1'b1) begin
         checks++; errors++;
         $display("FAIL aw_ready_timeout awready=%b required=1", AXI_AWREADY);
      end
      tick();
      AXI_AWVALID = 1'b0;
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      #1;
      checks++; if (AXI_AWREADY !== 1'b1) begin errors++; $display("FAIL reset_awready got=%b exp=1", AXI_AWREADY); end
      checks++; if ({awid0_fifo_wr_en, cmd0_wr_en, awid1_fifo_wr_en, cmd1_wr_en} !== 4'b0000) begin
         errors++; $display("FAIL reset_wr_en got=%b exp=0000", {awid0_fifo_wr_en, cmd0_wr_en, awid1_fifo_wr_en, cmd1_wr_en}); end
      checks++; if (wr_pending !== 1'b0) begin errors++; $display("FAIL reset_pending got=%b exp=0", wr_pending); end
      checks++; if (int'(dut.cnt0) !== 0 || int'(dut.cnt1) !== 0) begin
         errors++; $display("FAIL reset_counts got=%0d/%0d exp=0/0", dut.cnt0, dut.cnt1); end
   endtask

   task automatic test_single_write();
      do_reset();
      write_aw(3, 32'h0000_1000, 7, 2, 1);
      checks++; if (cmd0_wr_en !== 1'b1 || awid0_fifo_wr_en !== 1'b1) begin
         errors++; $display("FAIL single_wr_en got=%b%b exp=11", cmd0_wr_en, awid0_fifo_wr_en); end
      checks++; if (awid0_fifo_din !== 4'd3) begin errors++; $display("FAIL single_id got=%0d exp=3", awid0_fifo_din); end
      checks++; if (cmd0_din !== pack(32'h0000_1000, 8'd7, 3'd2, 2'd1)) begin
         errors++; $display("FAIL single_cmd got=%h exp=%h", cmd0_din, pack(32'h0000_1000, 8'd7, 3'd2, 2'd1)); end
      checks++; if (AXI_AWREADY !== 1'b0) begin errors++; $display("FAIL single_awready_low got=%b exp=0", AXI_AWREADY); end
      checks++; if (cmd1_wr_en !== 1'b0 || awid1_fifo_wr_en !== 1'b0) begin
         errors++; $display("FAIL single_other_tgt got=%b%b exp=00", cmd1_wr_en, awid1_fifo_wr_en); end
      tick();
      checks++; if (AXI_AWREADY !== 1'b1) begin errors++; $display("FAIL single_awready_high got=%b exp=1", AXI_AWREADY); end
      checks++; if (wr_pending !== 1'b1) begin errors++; $display("FAIL single_pending got=%b exp=1", wr_pending); end
      checks++; if (int'(dut.cnt0) !== 1) begin errors++; $display("FAIL single_cnt0 got=%0d exp=1", dut.cnt0); end
      tick();
      awid0_fifo_rd_en = 1'b1;
      tick();
      awid0_fifo_rd_en = 1'b0;
      checks++; if (int'(dut.cnt0) !== 0) begin errors++; $display("FAIL single_cnt0_retired got=%0d exp=0", dut.cnt0); end
      checks++; if (wr_pending !== 1'b1) begin errors++; $display("FAIL single_pending_lag got=%b exp=1", wr_pending); end
      tick();
      checks++; if (wr_pending !== 1'b0) begin errors++; $display("FAIL single_pending_clear got=%b exp=0", wr_pending); end
   endtask

   task automatic test_target_select();
      do_reset();
      write_aw(5, 32'h8000_0040, 0, 0, 1);
      checks++; if ({awid1_fifo_wr_en, cmd1_wr_en, awid0_fifo_wr_en, cmd0_wr_en} !== 4'b1100) begin
         errors++; $display("FAIL sel_wr_en got=%b exp=1100", {awid1_fifo_wr_en, cmd1_wr_en, awid0_fifo_wr_en, cmd0_wr_en}); end
      checks++; if (awid1_fifo_din !== 4'd5 || cmd1_din !== pack(32'h8000_0040, 8'd0, 3'd0, 2'd1)) begin
         errors++; $display("FAIL sel_data got=%0d/%h exp=5/%h", awid1_fifo_din, cmd1_din, pack(32'h8000_0040, 8'd0, 3'd0, 2'd1)); end
      tick();
      checks++; if (int'(dut.cnt1) !== 1 || int'(dut.cnt0) !== 0) begin
         errors++; $display("FAIL sel_counts got=%0d/%0d exp=1/0", dut.cnt1, dut.cnt0); end
   endtask

   task automatic test_back_to_back();
      int acc, pushes;
      do_reset();
      acc = 0; pushes = 0;
      AXI_AWVALID = 1'b1; AXI_AWID = 4'd1; AXI_AWADDR = 32'h8000_0000;
      AXI_AWLEN = 8'd3; AXI_AWSIZE = 3'd2; AXI_AWBURST = 2'd1;
      #1;
      for (int c = 0; c < 10; c++) begin
         if (AXI_AWREADY === 1'b1) acc++;
         if (cmd1_wr_en === 1'b1) pushes++;
         tick();
         #1;
      end
      AXI_AWVALID = 1'b0;
      checks++; if (acc !== 5) begin errors++; $display("FAIL b2b_accepts got=%0d exp=5", acc); end
      checks++; if (pushes !== 5) begin errors++; $display("FAIL b2b_pushes got=%0d exp=5", pushes); end
      checks++; if (int'(dut.cnt1) !== 5) begin errors++; $display("FAIL b2b_cnt1 got=%0d exp=5", dut.cnt1); end
   endtask

   task automatic test_outstanding_limit();
      int pushes;
      do_reset();
      pushes = 0;
      for (int i = 0; i < 9; i++) begin
         write_aw(i, AW'(32'h100 + i * 16), i, 2, 1);
         if (cmd0_wr_en === 1'b1) pushes++;
         if (i == 8) begin
            checks++; if (cmd0_wr_en !== 1'b0 || awid0_fifo_wr_en !== 1'b0 || AXI_AWREADY !== 1'b0) begin
               errors++; $display("FAIL limit_stall got=%b%b ready=%b exp=00 ready=0", cmd0_wr_en, awid0_fifo_wr_en, AXI_AWREADY); end
         end
         tick();
      end
      checks++; if (pushes !== 8) begin errors++; $display("FAIL limit_pushes got=%0d exp=8", pushes); end
      repeat (3) tick();
      checks++; if (AXI_AWREADY !== 1'b0 || cmd0_wr_en !== 1'b0) begin
         errors++; $display("FAIL limit_hold got ready=%b en=%b exp ready=0 en=0", AXI_AWREADY, cmd0_wr_en); end
      checks++; if (int'(dut.cnt0) !== 8) begin errors++; $display("FAIL limit_cnt0 got=%0d exp=8", dut.cnt0); end
      awid0_fifo_rd_en = 1'b1;
      #1;
      checks++; if (cmd0_wr_en !== 1'b0) begin errors++; $display("FAIL limit_no_early_push got=%b exp=0", cmd0_wr_en); end
      tick();
      awid0_fifo_rd_en = 1'b0;
      #1;
      checks++; if (cmd0_wr_en !== 1'b1 || awid0_fifo_wr_en !== 1'b1 || awid0_fifo_din !== 4'd8) begin
         errors++; $display("FAIL limit_release got=%b%b id=%0d exp=11 id=8", cmd0_wr_en, awid0_fifo_wr_en, awid0_fifo_din); end
      tick();
      checks++; if (int'(dut.cnt0) !== 8 || AXI_AWREADY !== 1'b1) begin
         errors++; $display("FAIL limit_after got cnt=%0d ready=%b exp cnt=8 ready=1", dut.cnt0, AXI_AWREADY); end
   endtask

   task automatic test_backpressure();
      do_reset();
      cmd1_full = 1'b1;
      write_aw(2, 32'h0000_0200, 3, 2, 1);
      checks++; if (cmd0_wr_en !== 1'b1 || awid0_fifo_wr_en !== 1'b1) begin
         errors++; $display("FAIL bp_t0_unblocked got=%b%b exp=11", cmd0_wr_en, awid0_fifo_wr_en); end
      tick();
      write_aw(6, 32'hC000_0000, 1, 3, 3);
      for (int c = 0; c < 4; c++) begin
         checks++; if ({awid0_fifo_wr_en, cmd0_wr_en, awid1_fifo_wr_en, cmd1_wr_en, AXI_AWREADY} !== 5'b00000) begin
            errors++; $display("FAIL bp_held got=%b exp=00000", {awid0_fifo_wr_en, cmd0_wr_en, awid1_fifo_wr_en, cmd1_wr_en, AXI_AWREADY}); end
         tick();
         #1;
      end
      cmd1_full = 1'b0;
      #1;
      checks++; if (cmd1_wr_en !== 1'b1 || awid1_fifo_wr_en !== 1'b1) begin
         errors++; $display("FAIL bp_release got=%b%b exp=11", cmd1_wr_en, awid1_fifo_wr_en); end
      checks++; if (awid1_fifo_din !== 4'd6 || cmd1_din !== pack(32'hC000_0000, 8'd1, 3'd3, 2'b11)) begin
         errors++; $display("FAIL bp_data got=%0d/%h exp=6/%h", awid1_fifo_din, cmd1_din, pack(32'hC000_0000, 8'd1, 3'd3, 2'b11)); end
      tick();
   endtask

   task automatic test_simul_push_retire();
      do_reset();
      for (int i = 0; i < 4; i++) begin
         write_aw(i, AW'(32'h40 * i), 0, 2, 1);
         tick();
      end
      checks++; if (int'(dut.cnt0) !== 4) begin errors++; $display("FAIL sim_cnt_pre got=%0d exp=4", dut.cnt0); end
      write_aw(9, 32'h0000_0400, 0, 2, 1);
      awid0_fifo_rd_en = 1'b1;
      #1;
      checks++; if (cmd0_wr_en !== 1'b1) begin errors++; $display("FAIL sim_push got=%b exp=1", cmd0_wr_en); end
      tick();
      awid0_fifo_rd_en = 1'b0;
      checks++; if (int'(dut.cnt0) !== 4) begin errors++; $display("FAIL sim_cnt_same got=%0d exp=4", dut.cnt0); end
      awid0_fifo_rd_en = 1'b1;
      repeat (4) tick();
      awid0_fifo_rd_en = 1'b0;
      checks++; if (int'(dut.cnt0) !== 0) begin errors++; $display("FAIL sim_cnt_drain got=%0d exp=0", dut.cnt0); end
      awid0_fifo_rd_en = 1'b1;
      tick();
      awid0_fifo_rd_en = 1'b0;
      checks++; if (int'(dut.cnt0) !== 0) begin errors++; $display("FAIL sim_underflow got=%0d exp=0", dut.cnt0); end
      tick();
      checks++; if (wr_pending !== 1'b0) begin errors++; $display("FAIL sim_pending got=%b exp=0", wr_pending); end
   endtask

   task automatic test_reset_mid_op();
      do_reset();
      for (int i = 0; i < 3; i++) begin
         write_aw(i, 32'h8000_0000 + AW'(i * 32), 1, 2, 1);
         tick();
      end
      cmd1_full = 1'b1;
      write_aw(7, 32'h8000_0100, 1, 2, 1);
      checks++; if (int'(dut.cnt1) !== 3 || AXI_AWREADY !== 1'b0 || cmd1_wr_en !== 1'b0) begin
         errors++; $display("FAIL rst_pre got cnt1=%0d ready=%b en=%b exp cnt1=3 ready=0 en=0", dut.cnt1, AXI_AWREADY, cmd1_wr_en); end
      #2;
      reset = 1'b1;
      #1;
      checks++; if (int'(dut.cnt0) !== 0 || int'(dut.cnt1) !== 0) begin
         errors++; $display("FAIL rst_counts got=%0d/%0d exp=0/0", dut.cnt0, dut.cnt1); end
      checks++; if (AXI_AWREADY !== 1'b1 || wr_pending !== 1'b0) begin
         errors++; $display("FAIL rst_status got ready=%b pend=%b exp ready=1 pend=0", AXI_AWREADY, wr_pending); end
      checks++; if ({awid0_fifo_wr_en, cmd0_wr_en, awid1_fifo_wr_en, cmd1_wr_en} !== 4'b0000) begin
         errors++; $display("FAIL rst_wr_en got=%b exp=0000", {awid0_fifo_wr_en, cmd0_wr_en, awid1_fifo_wr_en, cmd1_wr_en}); end
      tick();
      reset = 1'b0;
      cmd1_full = 1'b0;
      #1;
      for (int c = 0; c < 3; c++) begin
         checks++; if ({awid1_fifo_wr_en, cmd1_wr_en, AXI_AWREADY} !== 3'b001) begin
            errors++; $display("FAIL rst_dropped got=%b exp=001", {awid1_fifo_wr_en, cmd1_wr_en, AXI_AWREADY}); end
         tick();
         #1;
      end
   endtask

   // Reference model: one parked AW slot and a count of unretired writes per
   // target, advanced once per clock from the rules of the channel.
   task automatic test_random();
      bit             m_held, m_pend;
      logic [IDW-1:0] m_id;
      logic [AW-1:0]  m_addr;
      logic [7:0]     m_len;
      logic [2:0]     m_size;
      logic [1:0]     m_burst;
      int             m_tgt;
      int             m_cnt [2];
      bit             p [2];
      bit             r [2];
      do_reset();
      m_held = 0; m_pend = 0; m_cnt[0] = 0; m_cnt[1] = 0; m_tgt = 0;
      m_id = '0; m_addr = '0; m_len = '0; m_size = '0; m_burst = '0;
      for (int c = 0; c < 400; c++) begin
         AXI_AWVALID      = ($urandom_range(0, 9) < 6);
         AXI_AWID         = IDW'($urandom);
         AXI_AWADDR       = $urandom;
         AXI_AWLEN        = 8'($urandom);
         AXI_AWSIZE       = 3'($urandom);
         AXI_AWBURST      = 2'($urandom);
         awid0_fifo_full  = ($urandom_range(0, 3) == 0);
         awid1_fifo_full  = ($urandom_range(0, 3) == 0);
         cmd0_full        = ($urandom_range(0, 3) == 0);
         cmd1_full        = ($urandom_range(0, 3) == 0);
         awid0_fifo_rd_en = (m_cnt[0] > 0) && ($urandom_range(0, 2) == 0);
         awid1_fifo_rd_en = (m_cnt[1] > 0) && ($urandom_range(0, 2) == 0);
         #1;
         p[0] = m_held && m_tgt == 0 && !awid0_fifo_full && !cmd0_full && m_cnt[0] < MAXO;
         p[1] = m_held && m_tgt == 1 && !awid1_fifo_full && !cmd1_full && m_cnt[1] < MAXO;
         r[0] = awid0_fifo_rd_en;
         r[1] = awid1_fifo_rd_en;
         checks++; if (AXI_AWREADY !== !m_held) begin
            errors++; $display("FAIL rnd_awready cyc=%0d got=%b exp=%b", c, AXI_AWREADY, !m_held); end
         checks++; if ({awid0_fifo_wr_en, cmd0_wr_en, awid1_fifo_wr_en, cmd1_wr_en} !== {p[0], p[0], p[1], p[1]}) begin
            errors++; $display("FAIL rnd_wr_en cyc=%0d got=%b exp=%b", c,
                               {awid0_fifo_wr_en, cmd0_wr_en, awid1_fifo_wr_en, cmd1_wr_en}, {p[0], p[0], p[1], p[1]}); end
         if (p[0]) begin
            checks++; if (awid0_fifo_din !== m_id || cmd0_din !== pack(m_addr, m_len, m_size, m_burst)) begin
               errors++; $display("FAIL rnd_data0 cyc=%0d got=%h/%h exp=%h/%h", c, awid0_fifo_din, cmd0_din, m_id, pack(m_addr, m_len, m_size, m_burst)); end
         end
         if (p[1]) begin
            checks++; if (awid1_fifo_din !== m_id || cmd1_din !== pack(m_addr, m_len, m_size, m_burst)) begin
               errors++; $display("FAIL rnd_data1 cyc=%0d got=%h/%h exp=%h/%h", c, awid1_fifo_din, cmd1_din, m_id, pack(m_addr, m_len, m_size, m_burst)); end
         end
         checks++; if (wr_pending !== m_pend) begin
            errors++; $display("FAIL rnd_pending cyc=%0d got=%b exp=%b", c, wr_pending, m_pend); end
         checks++; if (int'(dut.cnt0) !== m_cnt[0] || int'(dut.cnt1) !== m_cnt[1]) begin
            errors++; $display("FAIL rnd_counts cyc=%0d got=%0d/%0d exp=%0d/%0d", c, dut.cnt0, dut.cnt1, m_cnt[0], m_cnt[1]); end
         m_pend = m_held || m_cnt[0] != 0 || m_cnt[1] != 0;
         for (int n = 0; n < 2; n++) begin
            if (p[n] && !r[n]) m_cnt[n]++;
            else if (r[n] && !p[n]) m_cnt[n]--;
         end
         if (!m_held && AXI_AWVALID) begin
            m_held = 1; m_id = AXI_AWID; m_addr = AXI_AWADDR; m_len = AXI_AWLEN;
            m_size = AXI_AWSIZE; m_burst = AXI_AWBURST; m_tgt = int'(AXI_AWADDR[SEL]);
         end else if (p[0] || p[1]) begin
            m_held = 0;
         end
         tick();
      end
      AXI_AWVALID = 1'b0;
      awid0_fifo_rd_en = 1'b0; awid1_fifo_rd_en = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog simulation did not complete");
      $fatal(1);
   end

   initial begin
      do_reset();
      test_reset();
      test_single_write();
      test_target_select();
      test_back_to_back();
      test_outstanding_limit();
      test_backpressure();
      test_simul_push_retire();
      test_reset_mid_op();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/rpc2_ctrl_axi_wr_address_channel2.md
RPC2_CTRL_AXI_WR_ADDRESS_CHANNEL2 -- requirements
Module: rpc2_ctrl_axi_wr_address_channel2

Interface
REQ-001 The block SHALL use one clock, and its reset SHALL be asynchronous and active-high.
REQ-002 Parameter C_AXI_ID_WIDTH, default 4, SHALL set the AXI ID width.
REQ-003 Parameter C_AXI_ADDR_WIDTH, default 32, SHALL set the AXI address width.
REQ-004 Parameter C_SEL_BIT, default 31, SHALL name the AWADDR bit that selects target 0 (bit=0) or target 1 (bit=1).
REQ-005 Parameter C_MAX_OUTSTANDING, default 8, SHALL set the maximum number of unretired writes per target.
REQ-006 Ports SHALL be:
- clk  in  1  clock
- reset  in  1  async active-high reset
- AXI_AWID  in  C_AXI_ID_WIDTH  write ID
- AXI_AWADDR  in  C_AXI_ADDR_WIDTH  address
- AXI_AWLEN  in  8  burst length-1
- AXI_AWSIZE  in  3  beat size
- AXI_AWBURST  in  2  burst type
- AXI_AWVALID  in  1  address valid
- AXI_AWREADY  out  1  address ready
- awidN_fifo_wr_en  out  1  push ID to target N response-ID FIFO (N=0,1)
- awidN_fifo_din  out  C_AXI_ID_WIDTH  ID pushed
- awidN_fifo_full  in  1  ID FIFO N full
- awidN_fifo_rd_en  in  1  retire pulse from the write-response side for target N
- cmdN_wr_en  out  1  push command to target N
- cmdN_din  out  C_AXI_ADDR_WIDTH+13  {AWADDR, AWLEN, AWSIZE, AWBURST}, MSB first
- cmdN_full  in  1  command FIFO N full
- wr_pending  out  1  registered status: any write held or outstanding

Function
REQ-007 A 1-entry holding register SHALL capture AWID, AWADDR, AWLEN, AWSIZE, AWBURST and sel=AWADDR[C_SEL_BIT] on the edge where AWVALID&AWREADY=1.
REQ-008 AXI_AWREADY SHALL be a register equal to ~hold_valid:
- it is 1 after reset;
- it is 0 in the cycle after acceptance;
- it is 1 again in the cycle after the push.
REQ-009 push_N SHALL be combinational and equal to hold_valid & (sel==N) & ~awidN_fifo_full & ~cmdN_full & (cntN < C_MAX_OUTSTANDING).
REQ-010 When push_N=1, awidN_fifo_wr_en and cmdN_wr_en SHALL both be 1 in the same cycle, and hold_valid SHALL clear at the next edge.
REQ-011 The ID FIFO and command FIFO of a target SHALL never be written one without the other.
REQ-012 At most one target SHALL be written per cycle, and the target that is not selected SHALL see its write enables at 0.
REQ-013 awidN_fifo_din and cmdN_din SHALL be driven from the holding register at all times; their values matter only while the write enable is 1.
REQ-014 Peak throughput SHALL be one AW every 2 cycles.
REQ-015 Counter cntN, of width $clog2(C_MAX_OUTSTANDING+1), SHALL update as follows:
- +1 on push_N alone;
- -1 on awidN_fifo_rd_en alone;
- unchanged when both occur in the same cycle.
REQ-016 A retire pulse while cntN==0 SHALL be ignored, so cntN never underflows.
REQ-017 When cntN==C_MAX_OUTSTANDING, the held command SHALL stall, and AWREADY SHALL stay 0 until a retire frees a slot.
REQ-018 A full FIFO on target 1 SHALL NOT block target 0; the stall applies only to the held command's own target.
REQ-019 AWBURST=2'b11 SHALL be forwarded unchanged, because error reporting belongs to the response path.
REQ-020 wr_pending SHALL be registered as hold_valid | (cnt0!=0) | (cnt1!=0), with one cycle of latency.

Reset
REQ-021 While reset=1, the block SHALL force:
- hold_valid=0;
- cnt0=cnt1=0;
- AXI_AWREADY=1;
- wr_pending=0;
- all holding-register fields to 0.
REQ-022 Write enables SHALL be 0 during reset, because they derive from hold_valid.
REQ-023 A reset asserted mid-operation SHALL drop any held command, with no partial push.

Structure
REQ-024 The command field widths and the cmdN_din bit-field offsets SHALL be shared constants in the rpc2_ctrl common package, so that command-FIFO consumers decode identically.
REQ-025 One sub-module, rpc2_ctrl_outstanding_counter (instantiated twice: inc, dec, count, at_max), SHALL be used, and everything else SHALL be flat.

Verification
REQ-026 Single write: reset, then AWVALID with ID=3, ADDR=0x0000_1000, LEN=7 -> in the next cycle cmd0_wr_en=awid0_fifo_wr_en=1, awid0_fifo_din=3; AWREADY goes 0 then 1; wr_pending=1 until awid0_fifo_rd_en is pulsed.
REQ-027 Target select: ADDR=0x8000_0040 -> only target 1 is written; cnt1=1 and cnt0=0.
REQ-028 Outstanding limit: 9 back-to-back writes to target 0 with no retires -> 8 pushes, and the 9th stays held with AWREADY=0; one awid0_fifo_rd_en pulse -> the 9th pushes in the following cycle.
REQ-029 FIFO backpressure: cmd1_full=1 while a target-1 command is held -> no write enables toggle; deasserting cmd1_full -> push in the same cycle.
REQ-030 Simultaneous push and retire on target 0 with cnt0=4 -> cnt0 stays 4; a retire pulse with cnt0=0 -> cnt0 stays 0.
REQ-031 Reset mid-operation: assert reset while a command is held and cnt1=3 -> all counts are 0, AWREADY=1, no write enable, wr_pending=0.
